map_query_server: RTL and testbench
===================================

// Module: map_query_server
// PURPOSE
//  Responder side of the wall-query interface used by movers (ghosts, pac-man): accepts
//  pixel-coordinate "is this a wall?" requests from N_REQ movers, arbitrates round-robin,
//  converts pixel coords to a tile address, reads the synchronous tile ROM and returns a
//  one-cycle isWall response to the granted requester. Sits between the movers and the map ROM.
// PARAMETERS
//  N_REQ       4    number of requesters (movers)
//  TILE_SHIFT  3    log2 tile size in pixels (8x8 tiles)
//  MAP_W_TILES 80   map width in tiles (640 px / 8)
//  MAP_H_TILES 60   map height in tiles (480 px / 8)
//  ADDR_W      13   tile ROM address width (>= clog2(MAP_W_TILES*MAP_H_TILES))
// PORTS
//  clk        in   1           system clock, all logic on posedge
//  rst_n      in   1           asynchronous active-low reset
//  req_valid  in   N_REQ       per-requester request; held high until its rsp_valid pulse
//  req_x      in   N_REQ*10    packed pixel X, requester i at [10*i +: 10]
//  req_y      in   N_REQ*9     packed pixel Y, requester i at [9*i +: 9]
//  rsp_valid  out  N_REQ       one-hot, one-cycle response pulse to the served requester
//  rsp_wall   out  1           wall result, valid only while any rsp_valid bit is high
//  rom_en     out  1           tile ROM read enable
//  rom_addr   out  ADDR_W      tile ROM address = (y>>TILE_SHIFT)*MAP_W_TILES + (x>>TILE_SHIFT)
//  rom_data   in   1           tile ROM data, 1 = wall; valid 1 cycle after rom_en
// BEHAVIOUR
//  Reset: state=IDLE, rsp_valid=0, rsp_wall=0, rom_en=0, rom_addr=0, last_grant=N_REQ-1.
//  FSM (all outputs registered): IDLE -> READ -> DATA -> RESP -> IDLE.
//   IDLE: if any req_valid, grant first set bit searching from last_grant+1 (mod N_REQ);
//         latch grant index and coords; last_grant<=index. Coords in range -> READ with
//         rom_en=1, rom_addr computed. Tile X >= MAP_W_TILES or tile Y >= MAP_H_TILES ->
//         RESP directly, wall=1, no ROM access.
//   READ: rom_en=0; ROM data arrives next cycle -> DATA.
//   DATA: capture rom_data into wall register -> RESP.
//   RESP: rsp_valid[idx]=1, rsp_wall=wall for exactly one cycle -> IDLE.
//  Latency: request sampled in IDLE at T -> rsp_valid at T+4 (in range), T+2 (out of range).
//  Throughput: one response per 4 cycles worst case; no request overlap, one in flight.
//  Handshake: requester deasserts (or changes coords and re-asserts) after its rsp_valid;
//   the served requester is masked from grant in the cycle following RESP, so a still-high
//   req_valid there is not re-served until the next IDLE evaluation after that.
//  Coords latched at grant; changes to req_x/req_y while pending are ignored.
//  req_valid dropped while pending: response still issued (harmless pulse).
//  Address arithmetic: unsigned, computed at ADDR_W bits; no wrap, out-of-range trapped above.
//  Reset mid-operation: in-flight request discarded, no response; requester still holding
//   req_valid is re-served normally after reset release.
// STRUCTURE
//  Shared package map_pkg: TILE_SHIFT, MAP_W_TILES, MAP_H_TILES, ADDR_W, coord widths
//   (X_W=10, Y_W=9), FSM state enum {IDLE,READ,DATA,RESP}.
//  One sub-module: map_rr_arbiter (N_REQ req vector + last_grant -> one-hot grant + index,
//   combinational, masked input). Address calc and FSM stay in this module.
// TESTING (bench supplies a behavioural 1-cycle-latency ROM with known wall pattern)
//  1. Single req0 at (16,8), tile (2,1) wall=1 -> rom_addr=82, rsp_valid=0001, rsp_wall=1 at T+4.
//  2. req0..req3 all held high from reset -> served in order 0,1,2,3,0; one pulse each 4 cycles.
//  3. req2 at x=640 (tile 80) -> no rom_en, rsp_valid=0100, rsp_wall=1 at T+2.
//  4. req1 coords changed (8,8)->(24,8) one cycle after grant -> response uses tile (1,1) data.
//  5. rst_n pulsed low during READ -> rsp_valid stays 0, outputs at reset values; after release
//     held req re-served with correct result.
//  6. req0 held continuously with req3 also pending -> req3 served before req0 is re-served.

Source files
------------

// File: rtl/map_pkg.sv
// map_pkg: shared map geometry, coordinate widths, FSM states and tile address helpers
package map_pkg;

   localparam int TILE_SHIFT  = 3;
   localparam int MAP_W_TILES = 80;
   localparam int MAP_H_TILES = 60;
   localparam int ADDR_W      = 13;
   localparam int X_W         = 10;
   localparam int Y_W         = 9;

   typedef enum logic [1:0] {IDLE, READ, DATA, RESP} state_t;

   // True when the pixel falls on a tile inside the map
   function automatic logic tile_in_range(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
      return (int'(x >> TILE_SHIFT) < MAP_W_TILES) && (int'(y >> TILE_SHIFT) < MAP_H_TILES);
   endfunction

   // Row-major tile index; only meaningful for in-range coordinates
   function automatic logic [ADDR_W-1:0] tile_addr(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
      return ADDR_W'(int'(y >> TILE_SHIFT) * MAP_W_TILES + int'(x >> TILE_SHIFT));
   endfunction

endpackage

// File: rtl/map_rr_arbiter.sv
// map_rr_arbiter: combinational round-robin pick starting one past the last grant
module map_rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [IDX_W-1:0] i_last,
   output logic [N_REQ-1:0] o_grant,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any
);

   logic [IDX_W-1:0] w_j;

   // Walk from farthest to nearest candidate so the nearest set bit after i_last wins
   always_comb begin
      o_grant = '0;
      o_idx   = i_last;
      o_any   = |i_req;
      w_j     = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         w_j = IDX_W'((int'(i_last) + k) % N_REQ);
         if (i_req[w_j]) begin
            o_grant      = '0;
            o_grant[w_j] = 1'b1;
            o_idx        = w_j;
         end
      end
   end

endmodule

// File: rtl/map_query_server.sv
// map_query_server: arbitrates mover wall queries, reads the tile ROM and returns isWall
module map_query_server
   import map_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [N_REQ*X_W-1:0] req_x,
   input  logic [N_REQ*Y_W-1:0] req_y,
   output logic [N_REQ-1:0]   rsp_valid,
   output logic               rsp_wall,
   output logic               rom_en,
   output logic [ADDR_W-1:0]  rom_addr,
   input  logic               rom_data
);

   localparam int IDX_W = $clog2(N_REQ);

   state_t              r_state, w_state;
   logic [IDX_W-1:0]    r_last, w_last;
   logic [N_REQ-1:0]    r_sel, w_sel;
   logic                r_wall, w_wall;
   logic [N_REQ-1:0]    r_rsp_valid, w_rsp_valid;
   logic                r_rsp_wall, w_rsp_wall;
   logic                r_rom_en, w_rom_en;
   logic [ADDR_W-1:0]   r_rom_addr, w_rom_addr;

   logic [N_REQ-1:0]    w_req, w_grant;
   logic [IDX_W-1:0]    w_idx;
   logic                w_any;
   logic [X_W-1:0]      w_x;
   logic [Y_W-1:0]      w_y;

   // The requester just answered is still asserting req_valid during its pulse; hide it
   assign w_req = req_valid & ~r_rsp_valid;

   map_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .i_req   (w_req),
      .i_last  (r_last),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   assign w_x = req_x[X_W*w_idx +: X_W];
   assign w_y = req_y[Y_W*w_idx +: Y_W];

   assign rsp_valid = r_rsp_valid;
   assign rsp_wall  = r_rsp_wall;
   assign rom_en    = r_rom_en;
   assign rom_addr  = r_rom_addr;

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_last      <= IDX_W'(N_REQ - 1);
         r_sel       <= '0;
         r_wall      <= 1'b0;
         r_rsp_valid <= '0;
         r_rsp_wall  <= 1'b0;
         r_rom_en    <= 1'b0;
         r_rom_addr  <= '0;
      end else begin
         r_state     <= w_state;
         r_last      <= w_last;
         r_sel       <= w_sel;
         r_wall      <= w_wall;
         r_rsp_valid <= w_rsp_valid;
         r_rsp_wall  <= w_rsp_wall;
         r_rom_en    <= w_rom_en;
         r_rom_addr  <= w_rom_addr;
      end
   end

   // Next state; out-of-map queries skip the ROM and report a wall
   always_comb begin
      w_state     = r_state;
      w_last      = r_last;
      w_sel       = r_sel;
      w_wall      = r_wall;
      w_rsp_valid = '0;
      w_rsp_wall  = 1'b0;
      w_rom_en    = 1'b0;
      w_rom_addr  = r_rom_addr;
      case (r_state)
         IDLE: if (w_any) begin
            w_last = w_idx;
            w_sel  = w_grant;
            if (tile_in_range(w_x, w_y)) begin
               w_state    = READ;
               w_rom_en   = 1'b1;
               w_rom_addr = tile_addr(w_x, w_y);
            end else begin
               w_state = RESP;
               w_wall  = 1'b1;
            end
         end
         READ: w_state = DATA;
         DATA: begin
            w_wall  = rom_data;
            w_state = RESP;
         end
         RESP: begin
            w_rsp_valid = r_sel;
            w_rsp_wall  = r_wall;
            w_state     = IDLE;
         end
         default: w_state = IDLE;
      endcase
   end

endmodule

// File: tb/tb_map_query_server.sv
// tb_map_query_server: scoreboard bench with a 1-cycle ROM and per-scenario tasks
module tb_map_query_server;

   typedef struct {
      int   idx;
      logic wall;
      int   addr;
      bit   inr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req_valid = '0;
   logic [39:0] req_x = '0;
   logic [35:0] req_y = '0;
   logic [3:0]  rsp_valid;
   logic        rsp_wall;
   logic        rom_en;
   logic [12:0] rom_addr;
   logic        rom_data = 1'b0;

   int   checks = 0;
   int   errors = 0;
   exp_t sbq[$];

   map_query_server #(.N_REQ(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_x     (req_x),
      .req_y     (req_y),
      .rsp_valid (rsp_valid),
      .rsp_wall  (rsp_wall),
      .rom_en    (rom_en),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data)
   );

   always #5 clk = ~clk;

   function automatic logic rom_pat(input int a);
      return ((a ^ (a >> 1) ^ (a >> 2)) & 1) != 0;
   endfunction

   always @(posedge clk) if (rom_en) rom_data <= rom_pat(int'(rom_addr));

   task automatic push(input int i, input int x, input int y);
      exp_t e;
      e.idx  = i;
      e.inr  = (x / 8 < 80) && (y / 8 < 60);
      e.addr = (y / 8) * 80 + x / 8;
      e.wall = e.inr ? rom_pat(e.addr) : 1'b1;
      sbq.push_back(e);
   endtask

   task automatic set_req(input int i, input int x, input int y);
      req_x[10*i +: 10] = 10'(x);
      req_y[9*i +: 9]   = 9'(y);
      req_valid[i]      = 1'b1;
   endtask

   task automatic wait_rsp(input int max, output int n, output logic [3:0] v);
      n = 0;
      v = '0;
      while (n < max && v == 4'b0) begin
         @(posedge clk);
         @(negedge clk);
         n++;
         v = rsp_valid;
      end
   endtask

   always @(negedge clk) begin
      if (rom_en === 1'b1) begin
         checks++;
         if (sbq.size() == 0 || !sbq[0].inr || rom_addr !== 13'(sbq[0].addr)) begin
            errors++;
            $display("FAIL rom_addr got %0d exp %0d (pending %0d)", rom_addr,
                     sbq.size() ? sbq[0].addr : -1, sbq.size());
         end
      end
      if (rsp_valid !== 4'b0) begin
         checks++;
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rsp got %b exp none", rsp_valid);
         end else begin
            exp_t e;
            logic [3:0] ev;
            e  = sbq.pop_front();
            ev = 4'(1 << e.idx);
            if (rsp_valid !== ev || rsp_wall !== e.wall) begin
               errors++;
               $display("FAIL rsp got valid=%b wall=%b exp valid=%b wall=%b", rsp_valid, rsp_wall, ev, e.wall);
            end
         end
      end
   end

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (rsp_valid !== 4'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0000", rsp_valid); end
      checks++;
      if (rsp_wall !== 1'b0) begin errors++; $display("FAIL reset_rsp_wall got %b exp 0", rsp_wall); end
      checks++;
      if (rom_en !== 1'b0) begin errors++; $display("FAIL reset_rom_en got %b exp 0", rom_en); end
      checks++;
      if (rom_addr !== 13'd0) begin errors++; $display("FAIL reset_rom_addr got %0d exp 0", rom_addr); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      int n;
      logic [3:0] v;
      push(0, 16, 8);
      set_req(0, 16, 8);
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (rom_en !== 1'b1 || rom_addr !== 13'd82) begin
         errors++;
         $display("FAIL single_rom got en=%b addr=%0d exp en=1 addr=82", rom_en, rom_addr);
      end
      wait_rsp(10, n, v);
      checks++;
      if (v !== 4'b0001 || n + 1 != 4) begin
         errors++;
         $display("FAIL single_rsp got %b lat %0d exp 0001 lat 4", v, n + 1);
      end
      req_valid[0] = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_all_held();
      int n;
      logic [3:0] v;
      int ord[5] = '{0, 1, 2, 3, 0};
      rst_n = 1'b0;
      set_req(0, 16, 8);
      set_req(1, 8, 8);
      set_req(2, 24, 8);
      set_req(3, 100, 200);
      push(0, 16, 8); push(1, 8, 8); push(2, 24, 8); push(3, 100, 200); push(0, 16, 8);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         wait_rsp(10, n, v);
         checks++;
         if (v !== 4'(1 << ord[k]) || n != 4) begin
            errors++;
            $display("FAIL all_held_%0d got %b gap %0d exp %b gap 4", k, v, n, 4'(1 << ord[k]));
         end
      end
      req_valid = '0;
      @(negedge clk);
   endtask

   task automatic test_out_of_range();
      int n;
      logic [3:0] v;
      int tab[4][4] = '{'{2, 640, 0, 2}, '{1, 0, 480, 2}, '{3, 639, 479, 4}, '{2, 1023, 511, 2}};
      for (int k = 0; k < 4; k++) begin
         push(tab[k][0], tab[k][1], tab[k][2]);
         set_req(tab[k][0], tab[k][1], tab[k][2]);
         wait_rsp(10, n, v);
         checks++;
         if (v !== 4'(1 << tab[k][0]) || n != tab[k][3]) begin
            errors++;
            $display("FAIL range_%0d got %b lat %0d exp %b lat %0d", k, v, n, 4'(1 << tab[k][0]), tab[k][3]);
         end
         req_valid = '0;
         @(negedge clk);
      end
   endtask

   task automatic test_coord_change();
      int n;
      logic [3:0] v;
      push(1, 8, 8);
      set_req(1, 8, 8);
      @(posedge clk);
      @(negedge clk);
      req_x[10 +: 10] = 10'd24;
      wait_rsp(10, n, v);
      checks++;
      if (v !== 4'b0010 || n + 1 != 4) begin
         errors++;
         $display("FAIL coord_change got %b lat %0d exp 0010 lat 4", v, n + 1);
      end
      req_valid = '0;
      @(negedge clk);
   endtask

   task automatic test_mask();
      int n;
      logic [3:0] v;
      push(1, 0, 0);
      push(1, 0, 0);
      set_req(1, 0, 0);
      wait_rsp(10, n, v);
      checks++;
      if (v !== 4'b0010 || n != 4) begin errors++; $display("FAIL mask_first got %b lat %0d exp 0010 lat 4", v, n); end
      wait_rsp(10, n, v);
      checks++;
      if (v !== 4'b0010 || n != 5) begin errors++; $display("FAIL mask_second got %b gap %0d exp 0010 gap 5", v, n); end
      req_valid = '0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int n;
      logic [3:0] v;
      push(0, 16, 8);
      set_req(0, 16, 8);
      @(posedge clk);
      #2 rst_n = 1'b0;
      sbq.delete();
      #1;
      checks++;
      if (rom_en !== 1'b0 || rom_addr !== 13'd0 || rsp_valid !== 4'b0 || rsp_wall !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid got en=%b addr=%0d v=%b w=%b exp all 0", rom_en, rom_addr, rsp_valid, rsp_wall);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (rsp_valid !== 4'b0) begin errors++; $display("FAIL reset_hold_%0d got %b exp 0000", k, rsp_valid); end
      end
      rst_n = 1'b1;
      push(0, 16, 8);
      wait_rsp(10, n, v);
      checks++;
      if (v !== 4'b0001 || n != 4) begin errors++; $display("FAIL reset_reserve got %b lat %0d exp 0001 lat 4", v, n); end
      req_valid = '0;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int n;
      logic [3:0] v;
      int ord[4] = '{0, 2, 3, 0};
      rst_n = 1'b0;
      set_req(0, 16, 8);
      set_req(2, 24, 8);
      set_req(3, 8, 16);
      push(0, 16, 8); push(2, 24, 8); push(3, 8, 16); push(0, 16, 8);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wait_rsp(10, n, v);
         if (k == 1) req_valid[2] = 1'b0;
         if (k == 2) req_valid[3] = 1'b0;
         checks++;
         if (v !== 4'(1 << ord[k]) || n != 4) begin
            errors++;
            $display("FAIL back_to_back_%0d got %b gap %0d exp %b gap 4", k, v, n, 4'(1 << ord[k]));
         end
      end
      req_valid = '0;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_all_held();
      test_out_of_range();
      test_coord_change();
      test_mask();
      test_reset_mid();
      test_back_to_back();
      repeat (6) @(negedge clk);
      checks++;
      if (sbq.size() != 0) begin errors++; $display("FAIL leftover_expected got %0d exp 0", sbq.size()); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
